// File: rtl/freq_sweep_ctrl_if.sv
// freq_sweep_ctrl_if: control/status bundle of the sweep sequencer.
// master drives start/stop/config and reads freq/busy/pulses; slave is the controller.
interface freq_sweep_ctrl_if #(
  parameter int FREQ_WIDTH  = 13,
  parameter int DWELL_WIDTH = 16
);
  logic                   start;
  logic                   stop;
  logic                   continuous;
  logic [FREQ_WIDTH-1:0]  f_start;
  logic [FREQ_WIDTH-1:0]  f_stop;
  logic [FREQ_WIDTH-1:0]  f_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [FREQ_WIDTH-1:0]  freq;
  logic                   busy;
  logic                   step_tick;
  logic                   sweep_done;

  modport master (
    output start, stop, continuous,
    output f_start, f_stop, f_step, dwell,
    input  freq, busy, step_tick, sweep_done
  );

  modport slave (
    input  start, stop, continuous,
    input  f_start, f_stop, f_step, dwell,
    output freq, busy, step_tick, sweep_done
  );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: frequency-sweep sequencer driving a generator freq word.
// Ports: clock, resetn (async low), bus (freq_sweep_ctrl_if.slave):
//   in  start/stop/continuous, f_start/f_stop/f_step, dwell
//   out freq (registered), busy, step_tick, sweep_done
// Optional: FREQ_SWEEP_BIDIR_EN adds the DOWN leg (triangle sweep).
module freq_sweep_ctrl #(
  parameter int FREQ_WIDTH  = 13,
  parameter int DWELL_WIDTH = 16
) (
  input logic              clock,
  input logic              resetn,
  freq_sweep_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
`ifdef FREQ_SWEEP_BIDIR_EN
  localparam logic [1:0] S_DOWN = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state;
  logic [FREQ_WIDTH-1:0]  freq_q;
  logic                   busy_q;
  logic                   tick_q;
  logic                   done_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  logic [FREQ_WIDTH-1:0]  sh_start;
  logic [FREQ_WIDTH-1:0]  sh_stop;
  logic [FREQ_WIDTH-1:0]  sh_step;
  logic [DWELL_WIDTH-1:0] sh_dwell;
  logic                   sh_cont;

  logic [FREQ_WIDTH-1:0]  step_eff;
  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [FREQ_WIDTH:0]    up_sum;
  logic [FREQ_WIDTH-1:0]  up_next;
  logic                   hold;
  logic                   adv;
  logic                   sweep_end;
  logic [FREQ_WIDTH-1:0]  adv_freq;
  logic [1:0]             adv_state;

  assign step_eff  = (bus.f_step == '0) ?
                     FREQ_WIDTH'(1) : bus.f_step;
  assign dwell_eff = (bus.dwell == '0) ?
                     DWELL_WIDTH'(1) : bus.dwell;

  // One extra bit so freq+step near full scale clamps instead of wrapping.
  assign up_sum  = {1'b0, freq_q} + {1'b0, sh_step};
  assign up_next = (up_sum > {1'b0, sh_stop}) ?
                   sh_stop : up_sum[FREQ_WIDTH-1:0];
  assign hold    = (dwell_cnt != '0);

`ifdef FREQ_SWEEP_BIDIR_EN
  logic [FREQ_WIDTH-1:0] dn_gap;
  logic [FREQ_WIDTH-1:0] dn_next;
  assign dn_gap  = freq_q - sh_start;
  assign dn_next = (dn_gap <= sh_step) ?
                   sh_start : freq_q - sh_step;
`endif

  always_comb begin
    adv       = 1'b0;
    sweep_end = 1'b0;
    adv_freq  = freq_q;
    adv_state = S_UP;
    if (state == S_UP && !hold) begin
      if (freq_q < sh_stop) begin
        adv      = 1'b1;
        adv_freq = up_next;
`ifdef FREQ_SWEEP_BIDIR_EN
      // f_stop has had its dwell; turn around without repeating it.
      end else if (freq_q > sh_start) begin
        adv       = 1'b1;
        adv_freq  = dn_next;
        adv_state = S_DOWN;
`endif
      end else begin
        sweep_end = 1'b1;
      end
    end
`ifdef FREQ_SWEEP_BIDIR_EN
    if (state == S_DOWN && !hold) begin
      if (freq_q > sh_start) begin
        adv       = 1'b1;
        adv_freq  = dn_next;
        adv_state = S_DOWN;
      end else begin
        sweep_end = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      freq_q    <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      dwell_cnt <= '0;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= FREQ_WIDTH'(1);
      sh_dwell  <= DWELL_WIDTH'(1);
      sh_cont   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state     <= S_IDLE;
        freq_q    <= '0;
        busy_q    <= 1'b0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state     <= S_UP;
              freq_q    <= bus.f_start;
              busy_q    <= 1'b1;
              dwell_cnt <= dwell_eff - 1'b1;
              sh_start  <= bus.f_start;
              sh_stop   <= bus.f_stop;
              sh_step   <= step_eff;
              sh_dwell  <= dwell_eff;
              sh_cont   <= bus.continuous;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            if (hold) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else if (adv) begin
              state     <= adv_state;
              freq_q    <= adv_freq;
              dwell_cnt <= sh_dwell - 1'b1;
              tick_q    <= 1'b1;
            end else if (sweep_end) begin
              done_q <= 1'b1;
              if (sh_cont) begin
                state     <= S_UP;
                freq_q    <= sh_start;
                dwell_cnt <= sh_dwell - 1'b1;
                tick_q    <= 1'b1;
              end else begin
                state <= S_DONE;
              end
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.freq       = freq_q;
  assign bus.busy       = busy_q;
  assign bus.step_tick  = tick_q;
  assign bus.sweep_done = done_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed bench for freq_sweep_ctrl.
// Expected per-cycle outputs are queued at stimulus time and popped each cycle.
module tb_freq_sweep_ctrl;
  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  freq_sweep_ctrl_if #(
    .FREQ_WIDTH(13),
    .DWELL_WIDTH(16)
  ) sif ();

  freq_sweep_ctrl #(
    .FREQ_WIDTH(13),
    .DWELL_WIDTH(16)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (sif.slave)
  );

  typedef struct packed {
    logic [12:0] f;
    logic        b;
    logic        t;
    logic        d;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".freq"}, 32'(sif.freq), 32'd0);
    chk({tag, ".busy"}, 32'(sif.busy), 32'd0);
    chk({tag, ".tick"}, 32'(sif.step_tick), 32'd0);
    chk({tag, ".done"}, 32'(sif.sweep_done), 32'd0);
  endtask

  task automatic step_cycle(input string tag);
    exp_t e;
    @(negedge clock);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, ".freq"}, 32'(sif.freq), 32'(e.f));
      chk({tag, ".busy"}, 32'(sif.busy), 32'(e.b));
      chk({tag, ".tick"}, 32'(sif.step_tick), 32'(e.t));
      chk({tag, ".done"}, 32'(sif.sweep_done), 32'(e.d));
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (sbq.size() != 0 && guard < 2000) begin
      step_cycle(tag);
      guard++;
    end
    chk({tag, ".drain"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic push_idle(input int f, input int n);
    exp_t e;
    e.f = 13'(f);
    e.b = 1'b0;
    e.t = 1'b0;
    e.d = 1'b0;
    repeat (n) sbq.push_back(e);
  endtask

  // Reference model: list of frequency values, then cycle-by-cycle outputs.
  task automatic plan(input int fs, input int fe,
                      input int st, input int dw,
                      input bit cont, input int ncyc);
    int   vals[$];
    int   v;
    int   s;
    int   w;
    int   k;
    bit   first;
    exp_t e;
    s = (st == 0) ? 1 : st;
    w = (dw == 0) ? 1 : dw;
    v = fs;
    vals.push_back(v);
    while (v < fe) begin
      v = (v + s > fe) ? fe : v + s;
      vals.push_back(v);
    end
`ifdef FREQ_SWEEP_BIDIR_EN
    while (v > fs) begin
      v = (v - s < fs) ? fs : v - s;
      vals.push_back(v);
    end
`endif
    k = 0;
    first = 1'b1;
    while (k < ncyc) begin
      foreach (vals[i]) begin
        for (int d = 0; d < w; d++) begin
          if (k < ncyc) begin
            e.f = 13'(vals[i]);
            e.b = 1'b1;
            e.t = (d == 0) && (i > 0 || !first);
            e.d = (d == 0) && (i == 0) && !first;
            sbq.push_back(e);
            k++;
          end
        end
      end
      first = 1'b0;
      if (!cont) begin
        e.f = 13'(vals[vals.size()-1]);
        e.b = 1'b1;
        e.t = 1'b0;
        e.d = 1'b1;
        sbq.push_back(e);
        push_idle(vals[vals.size()-1], 2);
        k = ncyc;
      end
    end
  endtask

  task automatic set_cfg(input int fs, input int fe,
                         input int st, input int dw,
                         input bit cont);
    sif.f_start    = 13'(fs);
    sif.f_stop     = 13'(fe);
    sif.f_step     = 13'(st);
    sif.dwell      = 16'(dw);
    sif.continuous = cont;
  endtask

  task automatic sweep(input string tag, input int fs,
                       input int fe, input int st,
                       input int dw);
    set_cfg(fs, fe, st, dw, 1'b0);
    sif.start = 1'b1;
    plan(fs, fe, st, dw, 1'b0, 1000);
    step_cycle(tag);
    sif.start = 1'b0;
    drain(tag);
  endtask

  initial begin
    resetn    = 1'b1;
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 1'b0);

    #1 resetn = 1'b0;
    #1 chk_zero("reset0");
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    push_idle(0, 2);
    drain("idle");

    // One-shot sweep, with config change and start pulse mid-sweep.
    set_cfg(100, 130, 10, 4, 1'b0);
    sif.start = 1'b1;
    plan(100, 130, 10, 4, 1'b0, 1000);
    step_cycle("oneshot");
    sif.start = 1'b0;
    repeat (5) step_cycle("oneshot");
    sif.f_start = 13'd500;
    sif.f_stop  = 13'd900;
    sif.start   = 1'b1;
    step_cycle("oneshot");
    sif.start = 1'b0;
    drain("oneshot");

    // start+stop together from IDLE: stop wins, freq forced to 0.
    set_cfg(100, 130, 10, 4, 1'b0);
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    push_idle(0, 3);
    step_cycle("startstop");
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    drain("startstop");

    sweep("clamp", 0, 25, 10, 0);
    sweep("zstep", 5, 7, 0, 2);
    sweep("rev", 50, 40, 3, 3);
    sweep("top", 8000, 8191, 100, 1);

    // Continuous sweeps, then abort.
    set_cfg(100, 130, 10, 4, 1'b1);
    sif.start = 1'b1;
    plan(100, 130, 10, 4, 1'b1, 40);
    step_cycle("cont");
    sif.start = 1'b0;
    drain("cont");
    sif.stop = 1'b1;
    push_idle(0, 3);
    step_cycle("contstop");
    sif.stop = 1'b0;
    drain("contstop");

    // Asynchronous reset in the middle of a sweep.
    set_cfg(100, 130, 10, 4, 1'b0);
    sif.start = 1'b1;
    step_cycle("midrst");
    sif.start = 1'b0;
    repeat (6) step_cycle("midrst");
    chk("midrst.pre_busy", 32'(sif.busy), 32'd1);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clock);
    resetn = 1'b1;
    push_idle(0, 3);
    drain("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
